// File: rtl/counter_sched_if.sv
// Requester-side bundle for counter_sched: level requests and lengths in,
// grant/done/busy status and the shared counter value out.
interface counter_sched_if #(
  parameter int BW   = 3,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*BW-1:0] len_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic               busy_o;
  logic [BW-1:0]      cnt_val_o;

  modport master (output req_i, len_i, input gnt_o, done_o, busy_o, cnt_val_o);
  modport slave  (input req_i, len_i, output gnt_o, done_o, busy_o, cnt_val_o);
endinterface

// File: rtl/counter_sched.sv
// Round-robin owner of a single BW-bit down-counter shared by NREQ requesters;
// the owner holds the counter for len+1 cycles and then gets a one-cycle done pulse.
module counter_sched #(
  parameter int BW   = 3,
  parameter int NREQ = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  counter_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;

  logic [PW-1:0] win;
  logic          win_vld;
  logic [PW-1:0] owner_nxt;

  // First requester at or after ptr, wrapping modulo NREQ; the descending loop
  // lets the lowest offset from ptr overwrite any later candidate.
  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (bus.req_i[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  assign owner_nxt = PW'((int'(owner_q) + 1) % NREQ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          cnt_d   = bus.len_i[int'(win)*BW +: BW];
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.req_i[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = owner_nxt;
          owner_d = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - BW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = owner_nxt;
        owner_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Outputs decode from state/owner/cnt only, so req_i never reaches them combinationally.
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.gnt_o     = (state_q != IDLE) ? (NREQ'(1) << owner_q) : '0;
  assign bus.done_o    = (state_q == DONE) ? (NREQ'(1) << owner_q) : '0;
  assign bus.cnt_val_o = cnt_q;
endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched (BW=3, NREQ=4): stimulus queues the expected
// per-cycle grant/done/count of every busy cycle, a monitor pops and compares.
module tb_counter_sched;
  localparam int BW = 3, NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_sched_if #(.BW(BW), .NREQ(NREQ)) bus ();
  counter_sched #(.BW(BW), .NREQ(NREQ)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [BW-1:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected trace of one full grant: cnt L..0 then the done cycle.
  task automatic push_grant(input int k, input int len);
    for (int c = len; c >= 0; c--) q.push_back('{gnt: NREQ'(1) << k, done: '0, cnt: BW'(c)});
    q.push_back('{gnt: NREQ'(1) << k, done: NREQ'(1) << k, cnt: '0});
  endtask

  task automatic push_partial(input int k, input int from, input int to);
    for (int c = from; c >= to; c--) q.push_back('{gnt: NREQ'(1) << k, done: '0, cnt: BW'(c)});
  endtask

  // Monitor: every busy cycle must match the queue head; a done cycle must be followed by idle.
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst) begin
      if (prev_done) begin
        checks++;
        if (bus.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap: busy=%b expected 0 after done", bus.busy_o);
        end
      end
      if (bus.busy_o || bus.gnt_o != '0 || bus.done_o != '0) begin
        act = '{gnt: bus.gnt_o, done: bus.done_o, cnt: bus.cnt_val_o};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy: got gnt=%b done=%b cnt=%0d with nothing expected",
                   act.gnt, act.done, act.cnt);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL cycle: got gnt=%b done=%b cnt=%0d expected gnt=%b done=%b cnt=%0d",
                     act.gnt, act.done, act.cnt, e.gnt, e.done, e.cnt);
          end
        end
      end
      prev_done = (bus.done_o != '0);
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.len_i = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o != '0) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s: no done pulse within 60 cycles", name);
    end
  endtask

  task automatic wait_cnt(input string name, input logic [NREQ-1:0] g, input logic [BW-1:0] c);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt_o == g && bus.cnt_val_o == c) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s: gnt=%b cnt=%0d never reached", name, g, c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_i = '0;
    bus.len_i = '0;

    // 1. reset: outputs quiet during and after reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_cnt", 32'(bus.cnt_val_o), 0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(bus.busy_o), 0);
    chk("idle_gnt", 32'(bus.gnt_o), 0);

    // 2. single request, len0=3
    do_reset();
    bus.len_i = {3'd0, 3'd0, 3'd0, 3'd3};
    bus.req_i = 4'b0001;
    push_grant(0, 3);
    wait_done("single_done");
    @(posedge clk); #1 bus.req_i = '0;
    @(negedge clk);
    chk("single_after_busy", 32'(bus.busy_o), 0);
    chk("single_after_gnt", 32'(bus.gnt_o), 0);

    // 3. round robin, all len=1, order 0,1,2,3,0
    do_reset();
    bus.len_i = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.req_i = 4'b1111;
    push_grant(0, 1); push_grant(1, 1); push_grant(2, 1); push_grant(3, 1); push_grant(0, 1);
    for (int n = 0; n < 5; n++) wait_done("rr_done");
    @(posedge clk); #1 bus.req_i = '0;
    repeat (2) @(negedge clk);

    // 4. zero length on requester 2
    do_reset();
    bus.len_i = {3'd5, 3'd0, 3'd5, 3'd5};
    bus.req_i = 4'b0100;
    push_grant(2, 0);
    wait_done("zero_done");
    @(posedge clk); #1 bus.req_i = '0;
    repeat (2) @(negedge clk);

    // 5. abort requester 0 at cnt=4, requester 1 (len 2) then takes over
    do_reset();
    bus.len_i = {3'd0, 3'd0, 3'd2, 3'd7};
    bus.req_i = 4'b0011;
    push_partial(0, 7, 4);
    push_grant(1, 2);
    wait_cnt("abort_reach", 4'b0001, 3'd4);
    bus.req_i = 4'b0010;
    bus.len_i = {3'd0, 3'd0, 3'd2, 3'd1};
    @(negedge clk);
    chk("abort_idle_busy", 32'(bus.busy_o), 0);
    chk("abort_no_done", 32'(bus.done_o), 0);
    chk("abort_cnt", 32'(bus.cnt_val_o), 0);
    wait_done("abort_next_done");
    @(posedge clk); #1 bus.req_i = '0;
    repeat (2) @(negedge clk);

    // 6. reset mid-RUN at cnt=5, then requester 0 wins again
    do_reset();
    bus.len_i = {3'd0, 3'd0, 3'd0, 3'd7};
    bus.req_i = 4'b0001;
    push_partial(0, 7, 5);
    wait_cnt("midrst_reach", 4'b0001, 3'd5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt_o), 0);
    chk("midrst_cnt", 32'(bus.cnt_val_o), 0);
    chk("midrst_busy", 32'(bus.busy_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.len_i = {3'd0, 3'd0, 3'd1, 3'd2};
    bus.req_i = 4'b0011;
    push_grant(0, 2);
    wait_done("midrst_done");
    @(posedge clk); #1 bus.req_i = '0;
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
